// File: rtl/control_sequencer.sv
//==============================================================================
// Module      : control_sequencer
// Description : Microstep sequencer and control decoder for the 4-bit bus CPU.
//               Fetch at T0-T1, execute at T2-T4. Strobes are decoded
//               combinationally from the current step, opcode and flags.
//               Optional macro SEQ_EARLY_END_EN: return to T0 right after the
//               last active execute step instead of always using five steps.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int STEPS    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_carry,
  input  logic                flag_zero,
  output logic                pc_ce,
  output logic                pc_oe,
  output logic                pc_ie,
  output logic                mar_ie,
  output logic                ram_oe,
  output logic                ram_ie,
  output logic                ir_ie,
  output logic                ir_oe,
  output logic                a_ie,
  output logic                a_oe,
  output logic                b_ie,
  output logic                alu_oe,
  output logic                alu_sub,
  output logic                flags_ie,
  output logic                out_ie,
  output logic                halted,
  output logic [2:0]          step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [OPCODE_W-1:0] c_OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] c_OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] c_OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] c_OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] c_OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] c_OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] c_OP_JC  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] c_OP_JZ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] c_OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] c_OP_HLT = OPCODE_W'(4'hF);
  localparam logic [2:0]          c_LAST_STEP = 3'(STEPS - 1);

  step_t r_step;
  step_t w_step_next;
  logic  r_halted;
  logic  w_halted_next;
  logic  w_active;
  step_t w_last;

  assign step   = r_step;
  assign halted = r_halted;

  // Final execute step of the current instruction; opcode is only meaningful
  // from T2 onward, and every value here is at least T2, so fetch is unaffected.
  always_comb begin
`ifdef SEQ_EARLY_END_EN
    case (opcode)
      c_OP_LDA, c_OP_STA: w_last = T3;
      c_OP_ADD, c_OP_SUB: w_last = T4;
      c_OP_HLT:           w_last = T4;
      default:            w_last = T2;
    endcase
`else
    w_last = step_t'(c_LAST_STEP);
`endif
  end

  // Next step / halt: advance while running, freeze at T2 when HLT executes.
  always_comb begin
    w_step_next   = r_step;
    w_halted_next = r_halted;
    if (run && !r_halted) begin
      if (r_step == T2 && opcode == c_OP_HLT) begin
        w_halted_next = 1'b1;
      end else if (r_step == w_last) begin
        w_step_next = T0;
      end else begin
        w_step_next = step_t'(r_step + 3'd1);
      end
    end
  end

  // State register; reset dominates run and halt and abandons any instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_step   <= T0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_step_next;
      r_halted <= w_halted_next;
    end
  end

  // Microcode decode; every strobe is held low unless actively running.
  always_comb begin
    w_active = !reset && run && !r_halted;
    pc_ce    = 1'b0;
    pc_oe    = 1'b0;
    pc_ie    = 1'b0;
    mar_ie   = 1'b0;
    ram_oe   = 1'b0;
    ram_ie   = 1'b0;
    ir_ie    = 1'b0;
    ir_oe    = 1'b0;
    a_ie     = 1'b0;
    a_oe     = 1'b0;
    b_ie     = 1'b0;
    alu_oe   = 1'b0;
    alu_sub  = 1'b0;
    flags_ie = 1'b0;
    out_ie   = 1'b0;
    if (w_active) begin
      case (r_step)
        T0: begin
          pc_oe  = 1'b1;
          mar_ie = 1'b1;
        end
        T1: begin
          ram_oe = 1'b1;
          ir_ie  = 1'b1;
          pc_ce  = 1'b1;
        end
        T2: begin
          case (opcode)
            c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
              ir_oe  = 1'b1;
              mar_ie = 1'b1;
            end
            c_OP_LDI: begin
              ir_oe = 1'b1;
              a_ie  = 1'b1;
            end
            c_OP_JMP: begin
              ir_oe = 1'b1;
              pc_ie = 1'b1;
            end
            c_OP_JC: begin
              ir_oe = flag_carry;
              pc_ie = flag_carry;
            end
            c_OP_JZ: begin
              ir_oe = flag_zero;
              pc_ie = flag_zero;
            end
            c_OP_OUT: begin
              a_oe   = 1'b1;
              out_ie = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            c_OP_LDA: begin
              ram_oe = 1'b1;
              a_ie   = 1'b1;
            end
            c_OP_ADD, c_OP_SUB: begin
              ram_oe = 1'b1;
              b_ie   = 1'b1;
            end
            c_OP_STA: begin
              a_oe   = 1'b1;
              ram_ie = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == c_OP_ADD || opcode == c_OP_SUB) begin
            alu_oe   = 1'b1;
            a_ie     = 1'b1;
            flags_ie = 1'b1;
            alu_sub  = (opcode == c_OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//==============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer: behavioural model of
//               the instruction timing and microcode, directed scenarios with
//               literal expectations, and randomized stimulus.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_sequencer;

  // Strobe vector bit masks (order matches act_strobes packing below).
  localparam logic [14:0] M_PC_CE    = 15'h4000;
  localparam logic [14:0] M_PC_OE    = 15'h2000;
  localparam logic [14:0] M_PC_IE    = 15'h1000;
  localparam logic [14:0] M_MAR_IE   = 15'h0800;
  localparam logic [14:0] M_RAM_OE   = 15'h0400;
  localparam logic [14:0] M_RAM_IE   = 15'h0200;
  localparam logic [14:0] M_IR_IE    = 15'h0100;
  localparam logic [14:0] M_IR_OE    = 15'h0080;
  localparam logic [14:0] M_A_IE     = 15'h0040;
  localparam logic [14:0] M_A_OE     = 15'h0020;
  localparam logic [14:0] M_B_IE     = 15'h0010;
  localparam logic [14:0] M_ALU_OE   = 15'h0008;
  localparam logic [14:0] M_ALU_SUB  = 15'h0004;
  localparam logic [14:0] M_FLAGS_IE = 15'h0002;
  localparam logic [14:0] M_OUT_IE   = 15'h0001;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic       flag_carry = 1'b0;
  logic       flag_zero = 1'b0;
  logic pc_ce, pc_oe, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie, ir_oe;
  logic a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie, halted;
  logic [2:0] step;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int m_step = 0;
  bit m_halt = 1'b0;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_ce(pc_ce), .pc_oe(pc_oe), .pc_ie(pc_ie), .mar_ie(mar_ie),
    .ram_oe(ram_oe), .ram_ie(ram_ie), .ir_ie(ir_ie), .ir_oe(ir_oe),
    .a_ie(a_ie), .a_oe(a_oe), .b_ie(b_ie), .alu_oe(alu_oe),
    .alu_sub(alu_sub), .flags_ie(flags_ie), .out_ie(out_ie),
    .halted(halted), .step(step)
  );

  always #5 clk = ~clk;

  wire [14:0] act_strobes = {pc_ce, pc_oe, pc_ie, mar_ie, ram_oe, ram_ie, ir_ie,
                             ir_oe, a_ie, a_oe, b_ie, alu_oe, alu_sub, flags_ie, out_ie};

  // Number of steps an instruction occupies.
  function automatic int instr_len(input logic [3:0] op);
`ifdef SEQ_EARLY_END_EN
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
`else
    return 5;
`endif
  endfunction

  // Microcode table: what the strobes must be at a given step.
  function automatic logic [14:0] exp_mask(input int st, input logic [3:0] op,
                                           input logic c, input logic z);
    logic [14:0] m;
    m = '0;
    if (st == 0) m = M_PC_OE | M_MAR_IE;
    else if (st == 1) m = M_RAM_OE | M_IR_IE | M_PC_CE;
    else begin
      case (op)
        4'h1: m = (st == 2) ? (M_IR_OE | M_MAR_IE) : (st == 3) ? (M_RAM_OE | M_A_IE) : '0;
        4'h2: m = (st == 2) ? (M_IR_OE | M_MAR_IE) : (st == 3) ? (M_RAM_OE | M_B_IE)
                              : (M_ALU_OE | M_A_IE | M_FLAGS_IE);
        4'h3: m = (st == 2) ? (M_IR_OE | M_MAR_IE) : (st == 3) ? (M_RAM_OE | M_B_IE)
                              : (M_ALU_OE | M_A_IE | M_FLAGS_IE | M_ALU_SUB);
        4'h4: m = (st == 2) ? (M_IR_OE | M_MAR_IE) : (st == 3) ? (M_A_OE | M_RAM_IE) : '0;
        4'h5: m = (st == 2) ? (M_IR_OE | M_A_IE) : '0;
        4'h6: m = (st == 2) ? (M_IR_OE | M_PC_IE) : '0;
        4'h7: m = (st == 2 && c) ? (M_IR_OE | M_PC_IE) : '0;
        4'h8: m = (st == 2 && z) ? (M_IR_OE | M_PC_IE) : '0;
        4'hE: m = (st == 2) ? (M_A_OE | M_OUT_IE) : '0;
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  // Model update on each active edge.
  always @(posedge clk) begin
    if (reset) begin
      m_step = 0;
      m_halt = 1'b0;
    end else if (run && !m_halt) begin
      if (m_step == 2 && opcode == 4'hF) m_halt = 1'b1;
      else if (m_step + 1 >= instr_len(opcode)) m_step = 0;
      else m_step = m_step + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [14:0] e;
    int drivers;
    #2;
    e = (reset || !run || m_halt) ? 15'h0 : exp_mask(m_step, opcode, flag_carry, flag_zero);
    tests++;
    if (step !== 3'(m_step)) begin
      fails++;
      $display("FAIL step @%0t: got %0d expected %0d", $time, step, m_step);
    end
    tests++;
    if (halted !== m_halt) begin
      fails++;
      $display("FAIL halted @%0t: got %0b expected %0b", $time, halted, m_halt);
    end
    tests++;
    if (act_strobes !== e) begin
      fails++;
      $display("FAIL strobes @%0t: got %h expected %h (step %0d op %h)",
               $time, act_strobes, e, m_step, opcode);
    end
    drivers = int'(pc_oe) + int'(ram_oe) + int'(ir_oe) + int'(a_oe) + int'(alu_oe);
    tests++;
    if (drivers > 1) begin
      fails++;
      $display("FAIL bus_drivers @%0t: got %0d expected <=1", $time, drivers);
    end
  end

  task automatic drive(input logic r, input logic rn, input logic [3:0] op,
                       input logic c, input logic z);
    @(negedge clk);
    reset = r; run = rn; opcode = op; flag_carry = c; flag_zero = z;
    #3;
  endtask

  task automatic lit(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  int seq_exp[$];
  int seq_act[$];

  initial begin
    // Reset for two clocks with run high.
    drive(1, 1, 4'h0, 0, 0);
    drive(1, 1, 4'h0, 0, 0);
    lit("reset_step", int'(step), 0);
    lit("reset_halted", int'(halted), 0);
    lit("reset_strobes", int'(act_strobes), 0);

    // ADD then SUB.
    drive(0, 1, 4'h2, 0, 0); lit("first_T0", int'(act_strobes), 'h2800);
    drive(0, 1, 4'h2, 0, 0); lit("add_T1", int'(act_strobes), 'h4500);
    drive(0, 1, 4'h2, 0, 0); lit("add_T2", int'(act_strobes), 'h0880);
    drive(0, 1, 4'h2, 0, 0); lit("add_T3", int'(act_strobes), 'h0410);
    drive(0, 1, 4'h2, 0, 0); lit("add_T4", int'(act_strobes), 'h004A);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'h3, 0, 0);
    drive(0, 1, 4'h3, 0, 0); lit("sub_T4", int'(act_strobes), 'h004E);

    // Conditional jumps, both flag values.
    for (int k = 0; k < 4; k++) begin
      logic [3:0] op;
      logic f;
      op = (k < 2) ? 4'h7 : 4'h8;
      f = k[0];
      drive(1, 1, op, 0, 0);
      drive(0, 1, op, f, f);
      drive(0, 1, op, f, f);
      drive(0, 1, op, f, f);
      lit("jump_T2", int'(act_strobes), f ? 'h1080 : 'h0000);
      drive(0, 1, op, f, f);
    end

    // Pause at T1.
    drive(1, 1, 4'h0, 0, 0);
    drive(0, 1, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 4'h0, 0, 0);
      lit("pause_step", int'(step), 1);
      lit("pause_strobes", int'(act_strobes), 0);
    end
    drive(0, 1, 4'h0, 0, 0); lit("resume_T1", int'(act_strobes), 'h4500);
    drive(0, 1, 4'h0, 0, 0); lit("resume_T2_step", int'(step), 2);

    // HLT.
    drive(1, 1, 4'hF, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 4'hF, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 4'h1, 1, 1);
      lit("halt_flag", int'(halted), 1);
      lit("halt_step", int'(step), 2);
    end
    drive(1, 1, 4'h0, 0, 0);
    drive(0, 1, 4'h0, 0, 0);
    lit("unhalt_halted", int'(halted), 0);
    lit("unhalt_step", int'(step), 0);

    // Program LDI, LDA, ADD: record the step sequence.
    drive(1, 1, 4'h0, 0, 0);
`ifdef SEQ_EARLY_END_EN
    seq_exp = '{0, 1, 2, 0, 1, 2, 3, 0, 1, 2, 3, 4, 0};
`else
    for (int i = 0; i < 16; i++) seq_exp.push_back(i % 5);
`endif
    for (int i = 0; i < seq_exp.size(); i++) begin
      logic [3:0] op;
`ifdef SEQ_EARLY_END_EN
      op = (i < 3) ? 4'h5 : (i < 7) ? 4'h1 : (i < 12) ? 4'h2 : 4'h0;
`else
      op = (i < 5) ? 4'h5 : (i < 10) ? 4'h1 : (i < 15) ? 4'h2 : 4'h0;
`endif
      drive(0, 1, op, 0, 0);
      seq_act.push_back(int'(step));
    end
    for (int i = 0; i < seq_exp.size(); i++) lit("prog_step", seq_act[i], seq_exp[i]);

    // Reset at ADD T3 abandons the instruction.
    drive(1, 1, 4'h2, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'h2, 0, 0);
    lit("pre_abort_step", int'(step), 3);
    drive(1, 1, 4'h2, 0, 0);
    drive(0, 1, 4'h2, 0, 0);
    lit("abort_step", int'(step), 0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0), op,
            1'($urandom), 1'($urandom));
    end

    @(negedge clk); #4;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
